via_shift_tx: RTL and testbench

VIA_SHIFT_TX -- requirements
Module: via_shift_tx

---
 rtl/via_shift_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_via_shift_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/via_shift_tx.sv
// Byte-to-serial transmitter driving a VIA 6522 shift register through CB1 (clock) and CB2 (data), MSB first.
// Latency: a byte accepted at edge N into an idle, empty block pops at N+1; each frame takes 16*DIV+GAP cycles.
// Backpressure: 2-entry input FIFO; in_ready is low while both entries are occupied (and while reset is held).
module via_shift_tx #(
    parameter int DIV = 8,
    parameter int GAP = 16
) (
    input  logic       master_clock,
    input  logic       not_reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       shift_clock,
    output logic       shift_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Counters count down to zero, so a phase of length L reloads with L-1.
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

    // Sequencer state
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_shreg;

    // FIFO storage: r_mem0 always holds the oldest byte
    logic [7:0] r_mem0;
    logic [7:0] r_mem1;
    logic [1:0] r_level;

    // Registered outputs
    logic       r_in_ready;
    logic       r_sclk;
    logic       r_sdat;
    logic       r_busy;
    logic       r_done;

    // Next-state and control wires
    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [2:0] w_bit_nxt;
    logic [7:0] w_shreg_nxt;
    logic       w_pop;
    logic       w_push;
    logic       w_wr_low;
    logic [1:0] w_level_nxt;
    logic       w_done_nxt;
    logic       w_sclk_nxt;
    logic       w_sdat_nxt;
    logic       w_busy_nxt;
    logic       w_in_ready_nxt;

    // A push is only taken against the registered in_ready; abort discards it.
    assign w_push = in_valid && r_in_ready && !abort;

    // Next-state logic for the shift sequencer, including the pop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
            w_bit_nxt   = 3'd0;
            w_shreg_nxt = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_level != 2'd0) begin
                        w_pop       = 1'b1;
                        w_shreg_nxt = r_mem0;
                        w_bit_nxt   = 3'd7;
                        w_cnt_nxt   = DIV_M1;
                        w_state_nxt = S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = DIV_M1;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_GAP;
                            w_cnt_nxt   = GAP_M1;
                        end else begin
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                            w_bit_nxt   = r_bit - 3'd1;
                            w_state_nxt = S_LOW;
                            w_cnt_nxt   = DIV_M1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FIFO occupancy after this edge; pop and push together leave it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (abort) begin
            w_level_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + 2'd1;
                2'b01:   w_level_nxt = r_level - 2'd1;
                default: w_level_nxt = r_level;
            endcase
        end
        // The incoming byte lands in the oldest slot when the FIFO is empty after any pop.
        w_wr_low = w_pop ? (r_level == 2'd1) : (r_level == 2'd0);
    end

    // Output values for the state being entered, so every output can be registered.
    always_comb begin
        w_sclk_nxt = 1'b1;
        w_sdat_nxt = 1'b1;
        case (w_state_nxt)
            S_LOW: begin
                w_sclk_nxt = 1'b0;
                w_sdat_nxt = w_shreg_nxt[7];
            end
            S_HIGH: begin
                w_sdat_nxt = r_sdat;
            end
            default: begin
                w_sclk_nxt = 1'b1;
                w_sdat_nxt = 1'b1;
            end
        endcase
        w_busy_nxt     = (w_state_nxt != S_IDLE) || (w_level_nxt != 2'd0);
        w_in_ready_nxt = (w_level_nxt != 2'd2);
    end

    // Sequencer state register.
    always_ff @(negedge master_clock or negedge not_reset) begin
        if (!not_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_bit   <= 3'd0;
            r_shreg <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Two-entry FIFO as a tiny shift queue: pops move entry 1 down to entry 0.
    always_ff @(negedge master_clock or negedge not_reset) begin
        if (!not_reset) begin
            r_mem0  <= 8'd0;
            r_mem1  <= 8'd0;
            r_level <= 2'd0;
        end else begin
            r_level <= w_level_nxt;
            if (!abort) begin
                if (w_pop) begin
                    r_mem0 <= r_mem1;
                end
                if (w_push) begin
                    if (w_wr_low) begin
                        r_mem0 <= in_data;
                    end else begin
                        r_mem1 <= in_data;
                    end
                end
            end
        end
    end

    // Output registers; reset forces the idle line levels immediately.
    always_ff @(negedge master_clock or negedge not_reset) begin
        if (!not_reset) begin
            r_in_ready <= 1'b0;
            r_sclk     <= 1'b1;
            r_sdat     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_sclk     <= w_sclk_nxt;
            r_sdat     <= w_sdat_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign shift_clock = r_sclk;
    assign shift_data  = r_sdat;
    assign busy        = r_busy;
    assign done        = r_done;
    assign level       = r_level;

endmodule

// File: tb/tb_via_shift_tx.sv
// Bench for via_shift_tx: frame-level reference model plus directed literal timing checks.
// Inputs are driven 1 time unit after the rising edge; the DUT acts on falling edges.
// Outputs are compared on every rising edge against the model.
module tb_via_shift_tx;
    localparam int DIV   = 2;
    localparam int GAP   = 4;
    localparam int FRAME = 16 * DIV + GAP;

    logic       master_clock = 1'b0;
    logic       not_reset    = 1'b1;
    logic [7:0] in_data      = 8'd0;
    logic       in_valid     = 1'b0;
    logic       abort        = 1'b0;
    logic       in_ready;
    logic       shift_clock;
    logic       shift_data;
    logic       busy;
    logic       done;
    logic [1:0] level;

    via_shift_tx #(.DIV(DIV), .GAP(GAP)) dut (
        .master_clock (master_clock),
        .not_reset    (not_reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .abort        (abort),
        .shift_clock  (shift_clock),
        .shift_data   (shift_data),
        .busy         (busy),
        .done         (done),
        .level        (level)
    );

    always #20 master_clock = ~master_clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Falling-edge counter: edge numbers used by the directed timing checks.
    always @(negedge master_clock) cyc++;

    // Reference model: a byte queue plus "cycles since pop" for the frame in flight.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'd0;
    logic       m_done   = 1'b0;
    logic       m_rdy    = 1'b0;

    always @(negedge master_clock or negedge not_reset) begin : model
        logic was_active;
        if (!not_reset) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_done   = 1'b0;
            m_rdy    = 1'b0;
        end else begin
            was_active = m_active;
            m_done     = 1'b0;
            if (abort) begin
                mq.delete();
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                if (was_active) begin
                    m_pos++;
                    if (m_pos == FRAME) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else if (mq.size() > 0) begin
                    m_byte   = mq.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end
                if (in_valid && m_rdy) mq.push_back(in_data);
            end
            m_rdy = (mq.size() < 2);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge master_clock) begin : cmp
        int   half;
        logic e_sclk;
        logic e_sdat;
        e_sclk = 1'b1;
        e_sdat = 1'b1;
        half   = 0;
        if (m_active && m_pos < 16 * DIV) begin
            half   = m_pos / DIV;
            e_sclk = half[0];
            e_sdat = m_byte[7 - half / 2];
        end
        check("shift_clock", shift_clock, e_sclk);
        check("shift_data", shift_data, e_sdat);
        check("done", done, m_done);
        check("level", level, mq.size());
        check("in_ready", in_ready, m_rdy);
        check("busy", busy, m_active || (mq.size() > 0));
    end

    // Monitor: rising shift_clock edges, sampled bits, completed bytes and done pulses.
    int         rise_cyc[$];
    logic       rise_bit[$];
    logic [7:0] got[$];
    int         done_cyc[$];
    logic       prev_sclk = 1'b1;
    logic [7:0] acc       = 8'd0;
    int         nbits     = 0;

    always @(posedge master_clock) begin
        if (shift_clock && !prev_sclk) begin
            rise_cyc.push_back(cyc);
            rise_bit.push_back(shift_data);
            acc = {acc[6:0], shift_data};
            nbits++;
        end
        if (done) begin
            done_cyc.push_back(cyc);
            if (nbits == 8) got.push_back(acc);
            nbits = 0;
        end
        if (!busy) nbits = 0;
        prev_sclk = shift_clock;
    end

    task automatic tick();
        @(posedge master_clock);
        #1;
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        rise_bit.delete();
        got.delete();
        done_cyc.delete();
    endtask

    // Valid/ready push; returns the falling-edge number at which the byte was taken.
    task automatic push(input logic [7:0] d, output int e_n);
        int t;
        t        = 0;
        e_n      = -1;
        in_valid = 1'b1;
        in_data  = d;
        while (e_n < 0 && t < 300) begin
            if (in_ready === 1'b1) e_n = cyc + 1;
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (e_n < 0) begin
            n_checks++;
            $display("FAIL push_timeout: byte %0h not accepted after %0d cycles", d, t);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < limit) begin
            tick();
            t++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles", name, busy, t);
        end
    endtask

    // Literal frame timing: rises at n+3+4k with MSB-first bits, done after edge n+37.
    task automatic check_frame(input string name, input logic [7:0] b, input int n);
        check({name, "_rises"}, rise_cyc.size(), 8);
        for (int k = 0; k < 8 && k < rise_cyc.size(); k++) begin
            check({name, "_rise_edge"}, rise_cyc[k], n + 3 + 4 * k);
            check({name, "_rise_bit"}, rise_bit[k], b[7 - k]);
        end
        check({name, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) check({name, "_done_edge"}, done_cyc[0], n + 37);
        check({name, "_got_count"}, got.size(), 1);
        if (got.size() > 0) check({name, "_byte"}, got[0], b);
    endtask

    initial begin : watchdog
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, n1, n2, n3, t;
        logic [7:0] exp_q[$];

        // Reset values while reset is held
        #2 not_reset = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_shift_clock", shift_clock, 1);
        check("rst_shift_data", shift_data, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_level", level, 0);
        not_reset = 1'b1;
        tick();
        check("in_ready_after_release", in_ready, 1);

        // Single byte 0xA5: full frame timing
        clear_mon();
        push(8'hA5, n);
        wait_idle("a5", 200);
        tick();
        check_frame("a5", 8'hA5, n);

        // Three back-to-back pushes, then a fourth that must wait for a pop
        clear_mon();
        push(8'h3C, n);
        push(8'hFF, n1);
        push(8'h01, n2);
        check("burst_push2_edge", n1, n + 1);
        check("burst_push3_edge", n2, n + 2);
        check("burst_full_level", level, 2);
        check("burst_full_in_ready", in_ready, 0);
        push(8'h77, n3);
        check("burst_push4_edge", n3, n + 39);
        wait_idle("burst", 400);
        tick();
        exp_q = '{8'h3C, 8'hFF, 8'h01, 8'h77};
        check("burst_got_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("burst_order", got[i], exp_q[i]);
        check("burst_done_count", done_cyc.size(), 4);
        for (int i = 0; i < 4 && i < done_cyc.size(); i++)
            check("burst_done_edge", done_cyc[i], n + 37 + 37 * i);

        // Abort during the third HIGH phase; a coincident push is discarded
        clear_mon();
        push(8'h80, n);
        t = 0;
        while (rise_cyc.size() < 3 && t < 100) begin
            tick();
            t++;
        end
        check("abort_third_rise", rise_cyc.size() >= 3 ? rise_cyc[2] : -1, n + 11);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_shift_clock", shift_clock, 1);
        check("abort_shift_data", shift_data, 1);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        repeat (60) tick();
        check("abort_no_done", done_cyc.size(), 0);
        check("abort_still_idle", busy, 0);

        // Reset during LOW of bit 5, then a clean frame
        clear_mon();
        push(8'hC3, n);
        while (cyc < n + 9) tick();
        check("pre_reset_low", shift_clock, 0);
        #5 not_reset = 1'b0;
        #1;
        check("midrst_shift_clock", shift_clock, 1);
        check("midrst_shift_data", shift_data, 1);
        check("midrst_busy", busy, 0);
        check("midrst_level", level, 0);
        check("midrst_in_ready", in_ready, 0);
        repeat (3) tick();
        not_reset = 1'b1;
        tick();
        clear_mon();
        push(8'h55, n);
        wait_idle("post_reset", 200);
        tick();
        check_frame("r55", 8'h55, n);

        // Simultaneous pop and push at level 1
        clear_mon();
        push(8'h12, n);
        push(8'h34, n1);
        check("popush_edge", n1, n + 1);
        check("popush_level", level, 1);
        check("popush_in_ready", in_ready, 1);
        wait_idle("popush", 200);
        tick();
        check("popush_got_count", got.size(), 2);
        if (got.size() > 0) check("popush_first", got[0], 8'h12);
        if (got.size() > 1) check("popush_second", got[1], 8'h34);

        // Randomised traffic with rare aborts, checked by the every-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            abort    = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_idle("random_drain", 200);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
